// File: rtl/conv_pkg.sv
// Shared definitions for the convolution job sequencer: register map,
// STATUS/CTRL bit positions and the sequencer state encoding.
package conv_pkg;

    localparam int N_TAPS = 9;

    localparam logic [4:0] REG_W1_0     = 5'd0;
    localparam logic [4:0] REG_W2_0     = 5'd9;
    localparam logic [4:0] REG_SRC_BASE = 5'd18;
    localparam logic [4:0] REG_DST_BASE = 5'd19;
    localparam logic [4:0] REG_PIX_CNT  = 5'd20;
    localparam logic [4:0] REG_CTRL     = 5'd21;
    localparam logic [4:0] REG_STATUS   = 5'd22;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_RES_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Bundle of config, ifmap-fetch, engine and result-write signals around the
// sequencer; master is the sequencer's view, slave the fabric/engine view.
interface conv_job_sequencer_if #(parameter int ADDR_W = 12);

    logic                    cfg_we;
    logic [4:0]              cfg_addr;
    logic [31:0]             cfg_wdata;
    logic [31:0]             cfg_rdata;

    logic                    mem_req;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [31:0]             mem_rdata;

    logic                    conv_start;
    logic [31:0]             conv_num;
    logic                    conv_num_valid;
    logic [8:0][15:0]        kernel_num_1;
    logic [8:0][15:0]        kernel_num_2;
    logic [15:0]             conv_ofmap;
    logic                    conv_dout_valid;
    logic                    conv_done;

    logic                    res_we;
    logic [ADDR_W-1:0]       res_addr;
    logic [15:0]             res_wdata;
    logic                    irq;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, mem_gnt, mem_rvalid, mem_rdata,
               conv_ofmap, conv_dout_valid, conv_done,
        output cfg_rdata, mem_req, mem_addr, conv_start, conv_num, conv_num_valid,
               kernel_num_1, kernel_num_2, res_we, res_addr, res_wdata, irq
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, mem_gnt, mem_rvalid, mem_rdata,
               conv_ofmap, conv_dout_valid, conv_done,
        input  cfg_rdata, mem_req, mem_addr, conv_start, conv_num, conv_num_valid,
               kernel_num_1, kernel_num_2, res_we, res_addr, res_wdata, irq
    );

endinterface

// File: rtl/conv_cfg_regs.sv
// Config register file: weights, job descriptor, CTRL/STATUS with sticky
// done/err flags and busy-gated writes.
module conv_cfg_regs
    import conv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [4:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    output logic [31:0]             cfg_rdata,
    input  logic                    busy,
    input  logic                    done_set,
    input  logic                    err_set,
    input  logic [CNT_W-1:0]        res_cnt,
    output logic [8:0][15:0]        w1,
    output logic [8:0][15:0]        w2,
    output logic [ADDR_W-1:0]       src_base,
    output logic [ADDR_W-1:0]       dst_base,
    output logic [CNT_W-1:0]        pix_cnt_cfg,
    output logic                    irq_en,
    output logic                    done,
    output logic                    go
);

    logic err;
    logic cfg_wr;
    logic status_wr;
    logic unused_wdata;

    assign cfg_wr       = cfg_we && !busy;
    assign status_wr    = cfg_we && (cfg_addr == REG_STATUS);
    assign go           = cfg_wr && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_GO];
    assign unused_wdata = ^cfg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1          <= '0;
            w2          <= '0;
            src_base    <= '0;
            dst_base    <= '0;
            pix_cnt_cfg <= '0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (cfg_wr) begin
                if (cfg_addr < REG_W2_0)
                    w1[cfg_addr[3:0]] <= cfg_wdata[15:0];
                else if (cfg_addr < REG_SRC_BASE)
                    w2[4'(cfg_addr - REG_W2_0)] <= cfg_wdata[15:0];
                else if (cfg_addr == REG_SRC_BASE)
                    src_base <= cfg_wdata[ADDR_W-1:0];
                else if (cfg_addr == REG_DST_BASE)
                    dst_base <= cfg_wdata[ADDR_W-1:0];
                else if (cfg_addr == REG_PIX_CNT)
                    pix_cnt_cfg <= cfg_wdata[CNT_W-1:0];
            end
            // irq_en stays writable mid-job; only go is gated by busy
            if (cfg_we && (cfg_addr == REG_CTRL))
                irq_en <= cfg_wdata[CTRL_IRQ_EN];
            if (done_set)
                done <= 1'b1;
            else if (status_wr && cfg_wdata[ST_DONE])
                done <= 1'b0;
            if (err_set)
                err <= 1'b1;
            else if (status_wr && cfg_wdata[ST_ERR])
                err <= 1'b0;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr < REG_W2_0) begin
            cfg_rdata[15:0] = w1[cfg_addr[3:0]];
        end else if (cfg_addr < REG_SRC_BASE) begin
            cfg_rdata[15:0] = w2[4'(cfg_addr - REG_W2_0)];
        end else begin
            case (cfg_addr)
                REG_SRC_BASE: cfg_rdata[ADDR_W-1:0] = src_base;
                REG_DST_BASE: cfg_rdata[ADDR_W-1:0] = dst_base;
                REG_PIX_CNT:  cfg_rdata[CNT_W-1:0]  = pix_cnt_cfg;
                REG_CTRL:     cfg_rdata[CTRL_IRQ_EN] = irq_en;
                REG_STATUS: begin
                    cfg_rdata[ST_BUSY]                 = busy;
                    cfg_rdata[ST_DONE]                 = done;
                    cfg_rdata[ST_ERR]                  = err;
                    cfg_rdata[ST_RES_LSB +: CNT_W]     = res_cnt;
                end
                default: cfg_rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/conv_job_sequencer.sv
// Job controller for the two-channel 3x3 conv engine: fetches ifmap words,
// streams them to the engine and writes results back to buffer memory.
//   state   | meaning
//   IDLE    | waiting for go
//   START   | conv_start pulse, pixel counter cleared
//   REQ     | ifmap read request held until granted
//   WAIT    | waiting for read data, forwarded to the engine
//   DRAIN   | all pixels sent, waiting for conv_done
module conv_job_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_job_sequencer_if.master  bus
);

    state_t              state;
    logic [CNT_W-1:0]    pix_cnt, pix_nxt, pix_cnt_cfg;
    logic [CNT_W-1:0]    res_cnt, res_base;
    logic [ADDR_W-1:0]   src_base, dst_base;
    logic [8:0][15:0]    w1, w2;
    logic [31:0]         cfg_rdata;
    logic                busy, go, done, irq_en, done_set, err_set;

    logic                mem_req, conv_start, conv_num_valid, res_we;
    logic [ADDR_W-1:0]   mem_addr, res_addr;
    logic [31:0]         conv_num;
    logic [15:0]         res_wdata;

    assign busy     = (state != S_IDLE);
    assign pix_nxt  = pix_cnt + CNT_W'(1);
    assign done_set = ((state == S_IDLE) && go && (pix_cnt_cfg == '0)) ||
                      ((state == S_DRAIN) && bus.conv_done);
    assign err_set  = bus.conv_done && (state != S_DRAIN);
    assign res_base = (state == S_START) ? '0 : res_cnt;

    conv_cfg_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (bus.cfg_we),
        .cfg_addr    (bus.cfg_addr),
        .cfg_wdata   (bus.cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .busy        (busy),
        .done_set    (done_set),
        .err_set     (err_set),
        .res_cnt     (res_cnt),
        .w1          (w1),
        .w2          (w2),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .pix_cnt_cfg (pix_cnt_cfg),
        .irq_en      (irq_en),
        .done        (done),
        .go          (go)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pix_cnt        <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            conv_start     <= 1'b0;
            conv_num       <= '0;
            conv_num_valid <= 1'b0;
        end else begin
            conv_start     <= 1'b0;
            conv_num_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go && (pix_cnt_cfg != '0)) begin
                        conv_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    pix_cnt  <= '0;
                    mem_req  <= 1'b1;
                    mem_addr <= src_base;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        conv_num       <= bus.mem_rdata;
                        conv_num_valid <= 1'b1;
                        pix_cnt        <= pix_nxt;
                        if (pix_nxt == pix_cnt_cfg) begin
                            state <= S_DRAIN;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= src_base + ADDR_W'(pix_nxt);
                            state    <= S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.conv_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A result arriving in START is the job's first, so it lands at DST_BASE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_wdata <= '0;
            res_cnt   <= '0;
        end else begin
            res_we <= bus.conv_dout_valid;
            if (bus.conv_dout_valid) begin
                res_addr  <= dst_base + ADDR_W'(res_base);
                res_wdata <= bus.conv_ofmap;
                res_cnt   <= res_base + CNT_W'(1);
            end else if (state == S_START) begin
                res_cnt <= '0;
            end
        end
    end

    assign bus.cfg_rdata      = cfg_rdata;
    assign bus.mem_req        = mem_req;
    assign bus.mem_addr       = mem_addr;
    assign bus.conv_start     = conv_start;
    assign bus.conv_num       = conv_num;
    assign bus.conv_num_valid = conv_num_valid;
    assign bus.kernel_num_1   = w1;
    assign bus.kernel_num_2   = w2;
    assign bus.res_we         = res_we;
    assign bus.res_addr       = res_addr;
    assign bus.res_wdata      = res_wdata;
    assign bus.irq            = done & irq_en;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench for conv_job_sequencer: random memory/engine responders, queue-based
// expectations for pixels, fetch addresses and result writes.
module tb_conv_job_sequencer;
    import conv_pkg::*;

    localparam int AW    = 12;
    localparam int AMASK = 4095;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_job_sequencer_if #(.ADDR_W(AW)) bus ();
    conv_job_sequencer #(.ADDR_W(AW), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    int src, dst, issued, stall_idx, stall_left, rv_wait;
    bit pending, req_seen;
    logic [AW-1:0] held_addr;
    logic [31:0] exp_pix[$];
    logic [31:0] exp_raddr[$];
    logic [31:0] exp_rdata[$];
    int pix_seen, start_seen, res_idx, res_todo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // memory: random stalls, one forced 5-cycle stall, random read latency
    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        pending = 0; req_seen = 0; stall_left = 0; rv_wait = 0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            if (!rst_n) begin
                pending = 0; req_seen = 0;
            end else if (pending) begin
                if (bus.mem_req) chk("one_outstanding", {31'd0, bus.mem_req}, 32'd0);
                if (rv_wait == 0) begin
                    bus.mem_rdata = $urandom; bus.mem_rvalid = 1'b1;
                    exp_pix.push_back(bus.mem_rdata);
                    pending = 0;
                end else rv_wait--;
            end else if (req_seen || bus.mem_req) begin
                if (!req_seen) begin
                    chk("mem_addr", {20'd0, bus.mem_addr}, (src + issued) & AMASK);
                    held_addr = bus.mem_addr; req_seen = 1;
                    stall_left = (issued == stall_idx) ? 5 : int'($urandom_range(0, 2));
                end else begin
                    chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
                    chk("mem_addr_hold", {20'd0, bus.mem_addr}, {20'd0, held_addr});
                end
                if (stall_left > 0) stall_left--;
                else begin
                    bus.mem_gnt = 1'b1; pending = 1; req_seen = 0; issued++;
                    rv_wait = int'($urandom_range(0, 2));
                end
            end
        end
    end

    // engine results at random times
    initial begin
        bus.conv_dout_valid = 1'b0; bus.conv_ofmap = '0;
        forever begin
            @(negedge clk);
            bus.conv_dout_valid = 1'b0;
            if (rst_n && res_todo > 0 && $urandom_range(0, 1) == 1) begin
                bus.conv_ofmap = 16'($urandom); bus.conv_dout_valid = 1'b1;
                exp_raddr.push_back((dst + res_idx) & AMASK);
                exp_rdata.push_back({16'd0, bus.conv_ofmap});
                res_idx++; res_todo--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.conv_start) start_seen++;
            if (bus.conv_num_valid) begin
                if (exp_pix.size() == 0) chk("pix_spurious", exp_pix.size(), 32'd1);
                else begin
                    chk("conv_num", bus.conv_num, exp_pix.pop_front());
                    pix_seen++;
                end
            end
            if (bus.res_we) begin
                if (exp_raddr.size() == 0) chk("res_spurious", exp_raddr.size(), 32'd1);
                else begin
                    chk("res_addr", {20'd0, bus.res_addr}, exp_raddr.pop_front());
                    chk("res_wdata", {16'd0, bus.res_wdata}, exp_rdata.pop_front());
                end
            end
        end
    end

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdata;
    endtask

    task automatic wait_pix(input int n);
        for (int i = 0; i < 4000 && pix_seen < n; i++) @(negedge clk);
        chk("pix_reached", pix_seen, n);
    endtask

    task automatic wait_res();
        for (int i = 0; i < 4000 && (res_todo > 0 || exp_raddr.size() > 0); i++) @(negedge clk);
        chk("res_drained", res_todo + exp_raddr.size(), 32'd0);
    endtask

    task automatic new_job(input int s, input int d, input int stall);
        src = s; dst = d; issued = 0; stall_idx = stall;
        pix_seen = 0; start_seen = 0; res_idx = 0; res_todo = 0;
    endtask

    task automatic flush_model();
        exp_pix.delete(); exp_raddr.delete(); exp_rdata.delete(); res_todo = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] wts[9];
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.conv_done = 1'b0;
        new_job(0, 0, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_conv_start", {31'd0, bus.conv_start}, 32'd0);
        chk("rst_res_we", {31'd0, bus.res_we}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_kernel1", bus.kernel_num_1[31:0], 32'd0);
        cfg_rd(REG_STATUS, rd); chk("rst_status", rd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // job 1: W1 = 1..9, 16 pixels, forced stall, busy writes, stray conv_done
        for (int i = 0; i < 9; i++) begin
            cfg_wr(5'(i), 32'(i + 1));
            cfg_wr(5'(i + 9), 32'd0);
        end
        new_job(int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)), 2);
        cfg_wr(REG_SRC_BASE, src); cfg_wr(REG_DST_BASE, dst);
        cfg_wr(REG_PIX_CNT, 32'd16); cfg_wr(REG_CTRL, 32'd2);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("kernel1_%0d", i), {16'd0, bus.kernel_num_1[i]}, 32'(i + 1));
            chk($sformatf("kernel2_%0d", i), {16'd0, bus.kernel_num_2[i]}, 32'd0);
        end
        cfg_rd(5'd4, rd); chk("rd_w1_4", rd, 32'd5);
        cfg_wr(REG_CTRL, 32'd3);
        chk("conv_start_pulse", {31'd0, bus.conv_start}, 32'd1);
        @(negedge clk);
        chk("conv_start_single", {31'd0, bus.conv_start}, 32'd0);
        chk("first_req", {31'd0, bus.mem_req}, 32'd1);
        res_todo = 5;
        wait_pix(1);
        cfg_wr(REG_W1_0, 32'h7);
        cfg_wr(REG_CTRL, 32'd3);
        chk("w1_locked", {16'd0, bus.kernel_num_1[0]}, 32'd1);
        for (int i = 0; i < 200 && !bus.mem_req; i++) @(negedge clk);
        bus.conv_done = 1'b1;
        @(negedge clk);
        bus.conv_done = 1'b0;
        cfg_rd(REG_STATUS, rd);
        chk("err_set", {29'd0, rd[2:0]}, 32'h5);
        cfg_wr(REG_STATUS, 32'h4);
        cfg_rd(REG_STATUS, rd); chk("err_clear", {30'd0, rd[2:1]}, 32'd0);
        wait_pix(16);
        wait_res();
        repeat (2) @(negedge clk);
        cfg_rd(REG_STATUS, rd); chk("drain_busy", {29'd0, rd[2:0]}, 32'h1);
        chk("drain_no_req", {31'd0, bus.mem_req}, 32'd0);
        chk("pix_exact", pix_seen, 32'd16);
        bus.conv_done = 1'b1;
        @(negedge clk);
        bus.conv_done = 1'b0;
        cfg_rd(REG_STATUS, rd); chk("job1_status", rd, 32'h0005_0002);
        chk("job1_irq", {31'd0, bus.irq}, 32'd1);
        chk("job1_single_start", start_seen, 32'd1);
        cfg_wr(REG_STATUS, 32'h2);
        cfg_rd(REG_STATUS, rd); chk("done_clear", rd, 32'h0005_0000);
        chk("irq_clear", {31'd0, bus.irq}, 32'd0);

        // zero-length job
        new_job(src, dst, -1);
        cfg_wr(REG_PIX_CNT, 32'd0);
        cfg_wr(REG_CTRL, 32'd3);
        cfg_rd(REG_STATUS, rd); chk("zero_job_status", rd, 32'h0005_0002);
        chk("zero_job_irq", {31'd0, bus.irq}, 32'd1);
        repeat (3) @(negedge clk);
        chk("zero_job_no_start", start_seen, 32'd0);
        chk("zero_job_no_req", {31'd0, bus.mem_req}, 32'd0);
        cfg_wr(REG_STATUS, 32'h2);

        // wrapping job aborted by reset at pixel 7
        for (int i = 0; i < 9; i++) wts[i] = 16'($urandom);
        for (int i = 0; i < 9; i++) cfg_wr(5'(i), {16'd0, wts[i]});
        new_job(4090, 4093, -1);
        cfg_wr(REG_SRC_BASE, src); cfg_wr(REG_DST_BASE, dst);
        cfg_wr(REG_PIX_CNT, 32'd12);
        cfg_wr(REG_CTRL, 32'd1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("kernel1_rand_%0d", i), {16'd0, bus.kernel_num_1[i]}, {16'd0, wts[i]});
        res_todo = 3;
        wait_pix(7);
        rst_n = 1'b0;
        flush_model();
        #1;
        chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("abort_conv_num_valid", {31'd0, bus.conv_num_valid}, 32'd0);
        chk("abort_conv_num", bus.conv_num, 32'd0);
        chk("abort_res_we", {31'd0, bus.res_we}, 32'd0);
        chk("abort_res_addr", {20'd0, bus.res_addr}, 32'd0);
        chk("abort_kernel1", {16'd0, bus.kernel_num_1[0]}, 32'd0);
        cfg_rd(REG_STATUS, rd); chk("abort_status", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // restart: wraps in both fetch and result addresses
        new_job(4090, 4093, 0);
        cfg_wr(REG_SRC_BASE, src); cfg_wr(REG_DST_BASE, dst);
        cfg_wr(REG_PIX_CNT, 32'd10);
        cfg_wr(REG_CTRL, 32'd1);
        @(negedge clk);
        res_todo = 6;
        wait_pix(10);
        wait_res();
        @(negedge clk);
        bus.conv_done = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_addr = REG_STATUS; bus.cfg_wdata = 32'h2;
        @(negedge clk);
        bus.conv_done = 1'b0; bus.cfg_we = 1'b0;
        cfg_rd(REG_STATUS, rd); chk("restart_status_set_wins", rd, 32'h0006_0002);
        chk("restart_irq_off", {31'd0, bus.irq}, 32'd0);
        chk("restart_single_start", start_seen, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_job_sequencer.md
# conv_job_sequencer

Job-level controller for the two-channel 3x3 convolution engine. It holds the 2x9 kernel weights and job descriptors in a register file written over a simple config port, fetches packed two-channel ifmap words from buffer memory, and streams them into the engine. It then writes the engine's ofmap results back to buffer memory and reports completion through a sticky status bit and an interrupt. It sits between the E203 config/memory fabric and the convolution engine.

## Interface
- ADDR_W, 12, word address width for memory and result ports
- CNT_W, 16, width of the pixel and result counters

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe
- cfg_addr  in  5  config register index
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  config read data, combinational from cfg_addr
- mem_req  out  1  ifmap read request
- mem_addr  out  ADDR_W  ifmap read address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  packed pixel; [15:0] is ch1, [31:16] is ch2
- conv_start  out  1  one-cycle pulse to the engine
- conv_num  out  32  pixel to the engine
- conv_num_valid  out  1  pixel strobe
- kernel_num_1, kernel_num_2  out  9x16  weights, stable while busy
- conv_ofmap  in  16  engine result
- conv_dout_valid  in  1  result strobe
- conv_done  in  1  engine job-complete pulse
- res_we  out  1  result write strobe
- res_addr  out  ADDR_W  result write address
- res_wdata  out  16  result data
- irq  out  1  done & irq_en

## Operation
- Register map:
  - 0–8: W1[i] = wdata[15:0]
  - 9–17: W2[i] = wdata[15:0]
  - 18: SRC_BASE
  - 19: DST_BASE
  - 20: PIX_CNT[CNT_W-1:0]
  - 21: CTRL, where bit0 = go (self-clearing) and bit1 = irq_en
  - 22: STATUS, where bit0 = busy, bit1 = done (sticky, write 1 to clear), bit2 = err (sticky, write 1 to clear), and [31:16] = res_cnt
  - All other addresses read 0 and ignore writes.
- Writes to 0–20 while busy are ignored. A go written while busy is ignored.
- FSM states: IDLE, START, REQ, WAIT, DRAIN.
  - IDLE: a go write leads to START. If PIX_CNT == 0, the block instead sets done and stays IDLE with no conv_start.
  - START: conv_start = 1 and pix_cnt = 0; goes to REQ.
  - REQ: mem_req = 1 with mem_addr = SRC_BASE + pix_cnt. mem_req holds until mem_gnt, then goes to WAIT.
  - WAIT: on mem_rvalid, the block registers the data onto conv_num and raises conv_num_valid for one cycle, then increments pix_cnt. If pix_cnt+1 == PIX_CNT it goes to DRAIN, otherwise to REQ.
  - DRAIN: on conv_done, sets done and goes to IDLE.
- Only one read is outstanding at a time.
- Results are captured in every state. Each conv_dout_valid produces res_we, res_addr = DST_BASE + res_cnt, res_wdata = conv_ofmap, and res_cnt++.
- res_cnt is cleared in START.
- A conv_done outside DRAIN sets err and does not change state.
- Address arithmetic is modulo 2^ADDR_W, so the address wraps silently.
- Resetting mid-job aborts the job with no partial done.

## Timing
- Reset values:
  - cfg registers, counters and flags: 0
  - all outputs: 0
  - state: IDLE
- A go written in cycle T gives conv_start at T+1 and the first mem_req at T+2.
- mem_rvalid in cycle T gives conv_num_valid at T+1. The next mem_req also starts at T+1.
- The result write path is registered: conv_dout_valid at T gives res_we at T+1.
- A conv_done in DRAIN at cycle T gives done = 1 and busy = 0 at T+1, and irq at T+1 if irq_en is set.
- mem_gnt and mem_rvalid may arrive in the same cycle as the request; the earliest mem_rvalid is the cycle after the grant.
- If a done-clear write coincides with done being set, the set wins.

## Structure
- A shared package conv_pkg holds:
  - the register index localparams (REG_W1_0 through REG_STATUS)
  - the state enum
  - the STATUS bit positions
- One sub-module, conv_cfg_regs, contains:
  - the register file
  - the read mux
  - the sticky done/err logic
  - the busy-based write gating
- conv_job_sequencer contains the FSM and the result writer.

## Test plan
- Write W1 = 1..9, W2 = 0 and PIX_CNT = 16, then go. Expect kernel_num_1[i] == i+1, one conv_start, 16 conv_num_valid pulses at addresses SRC_BASE..+15, and done after conv_done.
- Hold mem_gnt low for 5 cycles. Expect mem_req and mem_addr to stay stable and no duplicate pixels.
- PIX_CNT = 0, then go. Expect no conv_start and done = 1 one cycle later.
- Write go and W1[0] = 0x7 while busy. Expect both to be ignored, and the weights and job to continue unchanged.
- Pulse conv_done in REQ. Expect err = 1 and the job to continue. Writing 1 to STATUS bit2 then clears err.
- Assert rst_n low mid-stream at pixel 7. Expect all outputs at 0 and IDLE. A new go then restarts from SRC_BASE with res_cnt = 0.
